// File: rtl/moonbase_nibble_sram_pkg.sv
// Shared definitions for the nibble-serial SRAM: bus bit positions and phase encoding.
package moonbase_nibble_sram_pkg;

  // Bit positions inside the 8-bit CPU bus word
  localparam int STB_BIT  = 7;
  localparam int WE_N_BIT = 5;
  localparam int DSTB_BIT = 4;
  localparam int NIB_MSB  = 3;
  localparam int NIB_LSB  = 0;
  localparam int NIB_W    = 4;

  // Nibble phase: the high nibble always travels first
  typedef enum logic {
    PHASE_HI = 1'b0,
    PHASE_LO = 1'b1
  } phase_e;

  function automatic phase_e phase_flip(input phase_e p);
    return (p == PHASE_HI) ? PHASE_LO : PHASE_HI;
  endfunction

endpackage

// File: rtl/moonbase_nibble_mux.sv
// Byte-to-nibble select: picks the half of the addressed byte that the current phase carries.
module moonbase_nibble_mux
  import moonbase_nibble_sram_pkg::*;
(
  input  logic [7:0]       byte_in,
  input  phase_e           phase,
  output logic [NIB_W-1:0] nib_out
);

  // High nibble in phase 0, low nibble in phase 1
  always_comb begin
    nib_out = byte_in[7:4];
    if (phase == PHASE_LO) begin
      nib_out = byte_in[3:0];
    end
  end

endmodule

// File: rtl/moonbase_nibble_sram.sv
// Nibble-serial SRAM for a small CPU: address cycles latch the address, data cycles
// alternate high/low nibbles, writes collect the low nibble first and commit on the high one.
// A separate preload port can write whole bytes at any time and always wins over the CPU.
module moonbase_nibble_sram
  import moonbase_nibble_sram_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        bus_in,
  output logic [3:0]        nib_out,
  output logic              phase,
  output logic              data_write,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] addr_q, addr_d;
  phase_e            phase_q, phase_d;
  logic [NIB_W-1:0]  hold_q, hold_d;
  logic              conflict_q, conflict_d;

  logic              stb;
  logic              we_n;
  logic [NIB_W-1:0]  nib;
  logic [ADDR_W-1:0] bus_addr;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] rd_byte;
  logic [NIB_W-1:0]  mux_nib;

  logic              cpu_commit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign stb      = bus_in[STB_BIT];
  assign we_n     = bus_in[WE_N_BIT];
  assign nib      = bus_in[NIB_MSB:NIB_LSB];
  assign bus_addr = bus_in[ADDR_W-1:0];

  // Address is transparent during the strobe so a read needs no extra cycle
  assign eff_addr = stb ? bus_addr : addr_q;
  assign rd_byte  = mem_q[eff_addr];

  moonbase_nibble_mux u_mux (
    .byte_in (rd_byte),
    .phase   (phase_q),
    .nib_out (mux_nib)
  );

  // Next-state for address latch, phase, held low nibble, conflict flag and the write port
  always_comb begin
    addr_d     = addr_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    conflict_d = conflict_q;
    cpu_commit = 1'b0;

    if (stb) begin
      addr_d  = bus_addr;
      phase_d = PHASE_HI;
      hold_d  = '0;
    end else begin
      phase_d = phase_flip(phase_q);
      if (!we_n) begin
        if (phase_q == PHASE_LO) begin
          hold_d = nib;
        end else begin
          cpu_commit = !rst;
        end
      end
    end

    if (ld_valid && cpu_commit) begin
      conflict_d = 1'b1;
    end

    mem_we    = ld_valid || cpu_commit;
    mem_waddr = ld_valid ? ld_addr : addr_q;
    mem_wdata = ld_valid ? ld_data : {nib, hold_q};
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      phase_q    <= PHASE_HI;
      hold_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage array, deliberately untouched by reset so preloaded contents survive
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Outputs read as zero while reset is held
  always_comb begin
    nib_out    = rst ? '0 : mux_nib;
    phase      = (phase_q == PHASE_LO) && !rst;
    conflict   = conflict_q && !rst;
    data_write = stb | bus_in[DSTB_BIT];
  end

endmodule

// File: tb/tb_moonbase_nibble_sram.sv
// Self-checking bench for the nibble-serial SRAM: a vector table of bus cycles with
// expected outputs, a scoreboard queue between drive and check, and a random data_write run.
module tb_moonbase_nibble_sram;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic [3:0] nib_out;
  logic       phase;
  logic       data_write;
  logic       ld_valid;
  logic [6:0] ld_addr;
  logic [7:0] ld_data;
  logic       conflict;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] bus;
    logic       ld_valid;
    logic [6:0] ld_addr;
    logic [7:0] ld_data;
    logic       chk_nib;
    logic [3:0] nib;
    logic       chk_state;
    logic       phase;
    logic       conflict;
  } vec_t;

  typedef struct {
    string      name;
    logic       chk_nib;
    logic [3:0] nib;
    logic       chk_state;
    logic       phase;
    logic       conflict;
    logic       dw;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  moonbase_nibble_sram #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .nib_out    (nib_out),
    .phase      (phase),
    .data_write (data_write),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .conflict   (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string n, input logic r, input logic [7:0] b,
                        input logic lv, input logic [6:0] la, input logic [7:0] ld,
                        input logic cn, input logic [3:0] en, input logic ep, input logic ec);
    vec_t v;
    v.name = n; v.rst = r; v.bus = b; v.ld_valid = lv; v.ld_addr = la; v.ld_data = ld;
    v.chk_nib = cn; v.nib = en; v.chk_state = 1'b1; v.phase = ep; v.conflict = ec;
    vecs.push_back(v);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (data_write !== e.dw) begin
      errors++;
      $display("[TB] FAIL %s data_write: got %b expected %b", e.name, data_write, e.dw);
    end
    if (e.chk_nib) begin
      checks++;
      if (nib_out !== e.nib) begin
        errors++;
        $display("[TB] FAIL %s nib_out: got %h expected %h", e.name, nib_out, e.nib);
      end
    end
    if (e.chk_state) begin
      checks++;
      if (phase !== e.phase) begin
        errors++;
        $display("[TB] FAIL %s phase: got %b expected %b", e.name, phase, e.phase);
      end
      checks++;
      if (conflict !== e.conflict) begin
        errors++;
        $display("[TB] FAIL %s conflict: got %b expected %b", e.name, conflict, e.conflict);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst      = v.rst;
    bus_in   = v.bus;
    ld_valid = v.ld_valid;
    ld_addr  = v.ld_addr;
    ld_data  = v.ld_data;
    e.name      = v.name;
    e.chk_nib   = v.chk_nib;
    e.nib       = v.nib;
    e.chk_state = v.chk_state;
    e.phase     = v.phase;
    e.conflict  = v.conflict;
    e.dw        = v.bus[7] ? 1'b1 : v.bus[4];
    sb.push_back(e);
    #1;
    checkOutput();
  endtask

  initial begin
    vec_t rv;
    logic [7:0] rb;

    rst = 1'b1; bus_in = 8'h00; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);

    //      name            rst  bus    ldv  ld_addr ld_data chk nib  ph   cf
    addVec("rst_preload",   1, 8'h8A, 1, 7'h00, 8'hF0, 1, 4'h0, 0, 0);
    addVec("rd0_addr",      0, 8'h80, 0, 7'h00, 8'h00, 1, 4'hF, 0, 0);
    addVec("rd0_hi",        0, 8'h20, 0, 7'h00, 8'h00, 1, 4'hF, 0, 0);
    addVec("rd0_lo",        0, 8'h30, 0, 7'h00, 8'h00, 1, 4'h0, 1, 0);
    addVec("wr77_addr",     0, 8'hF7, 0, 7'h00, 8'h00, 0, 4'h0, 0, 0);
    addVec("wr77_c1",       0, 8'h0A, 0, 7'h00, 8'h00, 0, 4'h0, 0, 0);
    addVec("wr77_hold",     0, 8'h02, 0, 7'h00, 8'h00, 1, 4'h0, 1, 0);
    addVec("wr77_c2",       0, 8'h0E, 0, 7'h00, 8'h00, 1, 4'hA, 0, 0);
    addVec("rd77_addr",     0, 8'hF7, 0, 7'h00, 8'h00, 1, 4'h2, 1, 0);
    addVec("rd77_hi",       0, 8'h20, 0, 7'h00, 8'h00, 1, 4'hE, 0, 0);
    addVec("rd77_lo",       0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h2, 1, 0);
    addVec("wr15_addr",     0, 8'h95, 0, 7'h00, 8'h00, 0, 4'h0, 0, 0);
    addVec("wr15_first",    0, 8'h05, 0, 7'h00, 8'h00, 0, 4'h0, 0, 0);
    addVec("rd15_lo",       0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h0, 1, 0);
    addVec("rd15_hi",       0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h5, 0, 0);
    addVec("wen_lo",        0, 8'h25, 0, 7'h00, 8'h00, 1, 4'h0, 1, 0);
    addVec("wen_hi",        0, 8'h2F, 0, 7'h00, 8'h00, 1, 4'h5, 0, 0);
    addVec("wen_lo_after",  0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h0, 1, 0);
    addVec("wen_hi_after",  0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h5, 0, 0);
    addVec("cf_addr10",     0, 8'h90, 0, 7'h00, 8'h00, 0, 4'h0, 1, 0);
    addVec("cf_same",       0, 8'h07, 1, 7'h10, 8'h33, 0, 4'h0, 0, 0);
    addVec("cf_rd10_lo",    0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h3, 1, 1);
    addVec("cf_rd10_hi",    0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h3, 0, 1);
    addVec("cf_addr15",     0, 8'h95, 0, 7'h00, 8'h00, 1, 4'h0, 1, 1);
    addVec("cf_diff",       0, 8'h09, 1, 7'h40, 8'h5A, 1, 4'h5, 0, 1);
    addVec("cf_rd15_lo",    0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h0, 1, 1);
    addVec("cf_rd15_hi",    0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h5, 0, 1);
    addVec("cf_rd40_addr",  0, 8'hC0, 0, 7'h00, 8'h00, 1, 4'hA, 1, 1);
    addVec("cf_rd40_hi",    0, 8'h30, 0, 7'h00, 8'h00, 1, 4'h5, 0, 1);
    addVec("mr_addr0",      0, 8'h80, 0, 7'h00, 8'h00, 1, 4'h0, 1, 1);
    addVec("mr_skip_hi",    0, 8'h20, 0, 7'h00, 8'h00, 1, 4'hF, 0, 1);
    addVec("mr_hold_c",     0, 8'h0C, 0, 7'h00, 8'h00, 1, 4'h0, 1, 1);
    addVec("mr_rst",        1, 8'h20, 0, 7'h00, 8'h00, 1, 4'h0, 0, 0);
    addVec("mr_commit_a",   0, 8'h0A, 0, 7'h00, 8'h00, 1, 4'hF, 0, 0);
    addVec("mr_rd0_lo",     0, 8'h20, 0, 7'h00, 8'h00, 1, 4'h0, 1, 0);
    addVec("mr_rd0_hi",     0, 8'h20, 0, 7'h00, 8'h00, 1, 4'hA, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Random bus traffic for data_write; data cycles keep WE_N high so memory is left alone
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (!rb[7]) rb[5] = 1'b1;
      rv.name = $sformatf("dw_rand%0d", i);
      rv.rst = 1'b0; rv.bus = rb; rv.ld_valid = 1'b0; rv.ld_addr = '0; rv.ld_data = '0;
      rv.chk_nib = 1'b0; rv.nib = '0; rv.chk_state = 1'b0; rv.phase = 1'b0; rv.conflict = 1'b0;
      applyStimulus(rv);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
